// File: rtl/cache_ro_pkg.sv
// Shared types and default sizes for the read-only cache controller.
// Latency: none (definitions only).
// Backpressure: n/a.
package cache_ro_pkg;

  localparam int SIZE_BLOCK_DEF = 32;
  localparam int BIT_TOTAL_DEF  = 24;
  localparam int NUM_REQ_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/cache_ro_ctrl_rr_arbiter.sv
// Round-robin pick of the first requester strictly after the pointer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] cand;
  logic        found;

  // Walk ptr+1, ptr+2, ... (mod N) and take the first active request.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, i_ptr} + (IW+1)'(off);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && i_req[cand[IW-1:0]]) begin
        found                 = 1'b1;
        o_gnt[cand[IW-1:0]]   = 1'b1;
        o_gnt_idx             = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cache_ro_ctrl.sv
// Shares one read-only block cache among NUM_REQ clients; misses are filled over Avalon-MM.
// Latency: hit responds 3 cycles after the request is seen in IDLE; a miss adds the Avalon wait.
// Backpressure: one transaction in flight; other clients hold valid until their ack pulse.
// Optional: CACHE_RO_CTRL_STATS_EN adds saturating hit/miss counters.
module cache_ro_ctrl
  import cache_ro_pkg::*;
#(
  parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
  parameter int BIT_TOTAL  = BIT_TOTAL_DEF,
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int BIT_OFFSET = $clog2(SIZE_BLOCK/8)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
`ifdef CACHE_RO_CTRL_STATS_EN
  output logic [31:0]                     o_hit_cnt,
  output logic [31:0]                     o_miss_cnt,
`endif
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*BIT_TOTAL-1:0]    i_req_addr,
  output logic [NUM_REQ-1:0]              o_req_ack,
  output logic [NUM_REQ-1:0]              o_resp_valid,
  output logic [SIZE_BLOCK-1:0]           o_resp_data,
  output logic                            o_c_en,
  output logic                            o_c_wrt,
  output logic [BIT_TOTAL-1:0]            o_c_addr,
  output logic [SIZE_BLOCK-1:0]           o_c_data,
  input  logic [SIZE_BLOCK-1:0]           i_c_data,
  input  logic                            i_c_success,
  output logic                            o_mem_read,
  output logic [BIT_TOTAL+BIT_OFFSET-1:0] o_mem_addr,
  input  logic                            i_mem_waitrequest,
  input  logic [SIZE_BLOCK-1:0]           i_mem_readdata,
  input  logic                            i_mem_readdatavalid
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
  localparam int          MAW     = BIT_TOTAL + BIT_OFFSET;

  ctrl_state_e state_q, state_d;

  logic [IW-1:0]         ptr_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [BIT_TOTAL-1:0]  addr_q;
  logic [SIZE_BLOCK-1:0] data_q;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic [BIT_TOTAL-1:0]  addr_sel;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (ptr_q),
    .o_gnt     (arb_gnt),
    .o_gnt_idx (arb_idx)
  );

  // Pick the granted client's block index out of the packed address bus.
  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        addr_sel = i_req_addr[k*BIT_TOTAL +: BIT_TOTAL];
      end
    end
  end

  // State register; reset abandons any transaction, including an outstanding Avalon read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: lookup, then either respond on a hit or go fetch and fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|i_req_valid) state_d = LOOKUP;
      LOOKUP:   state_d = CHECK;
      CHECK:    state_d = i_c_success ? RESP : MEM_REQ;
      MEM_REQ:  if (!i_mem_waitrequest) state_d = MEM_WAIT;
      MEM_WAIT: if (i_mem_readdatavalid) state_d = FILL;
      FILL:     state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture the grant in IDLE and the block data from whichever source supplies it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= PTR_RST;
      gnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == IDLE && |i_req_valid) begin
        ptr_q  <= arb_idx;
        gnt_q  <= arb_gnt;
        addr_q <= addr_sel;
      end
      if (state_q == CHECK && i_c_success) begin
        data_q <= i_c_data;
      end
      // Readdatavalid outside MEM_WAIT (e.g. a read orphaned by reset) is dropped here.
      if (state_q == MEM_WAIT && i_mem_readdatavalid) begin
        data_q <= i_mem_readdata;
      end
    end
  end

  // Outputs are pure state decodes so every bus reads zero whenever it is not in use.
  always_comb begin
    o_req_ack    = '0;
    o_resp_valid = '0;
    o_resp_data  = '0;
    o_c_en       = 1'b0;
    o_c_wrt      = 1'b0;
    o_c_addr     = '0;
    o_c_data     = '0;
    o_mem_read   = 1'b0;
    o_mem_addr   = '0;
    case (state_q)
      LOOKUP: begin
        o_req_ack = gnt_q;
        o_c_en    = 1'b1;
        o_c_addr  = addr_q;
      end
      MEM_REQ: begin
        o_mem_read = 1'b1;
        o_mem_addr = MAW'(addr_q) << BIT_OFFSET;
      end
      FILL: begin
        o_c_en   = 1'b1;
        o_c_wrt  = 1'b1;
        o_c_addr = addr_q;
        o_c_data = data_q;
      end
      RESP: begin
        o_resp_valid = gnt_q;
        o_resp_data  = data_q;
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_RO_CTRL_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Count lookup outcomes; counters stick at all-ones rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state_q == CHECK) begin
      if (i_c_success) begin
        if (o_hit_cnt != CNT_MAX) o_hit_cnt <= o_hit_cnt + 32'd1;
      end else begin
        if (o_miss_cnt != CNT_MAX) o_miss_cnt <= o_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
